// File: rtl/dnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dnn_pkg
// Brief    : Shared pixel type and window geometry for the DNN stream blocks.
// Revision : 1.0
// ============================================================================
package dnn_pkg;
    localparam int DATA_W = 16;
    typedef logic signed [DATA_W-1:0] pixel_t;
    localparam int WIN_K  = 3;
    localparam int WIN_N  = WIN_K * WIN_K;
endpackage
`default_nettype wire

// File: rtl/window_gen_3x3_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer
// Brief    : One-row pixel store, shared read/write address, read-old-data.
// Revision : 1.0
// ============================================================================
module line_buffer
    import dnn_pkg::*;
#(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Contents are never observed before being overwritten, so no reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module   : window_gen_3x3
// Brief    : Streaming 3x3 sliding-window generator feeding max-pooling.
//            Define WINDOW_STRIDE2_EN to emit only stride-2 windows.
// Revision : 1.0
// ============================================================================
module window_gen_3x3 #(
    parameter int DATA_W = dnn_pkg::DATA_W,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic                     frame_start,
    input  logic signed [DATA_W-1:0] pixel_in,
    output logic signed [DATA_W-1:0] data_out0,
    output logic signed [DATA_W-1:0] data_out1,
    output logic signed [DATA_W-1:0] data_out2,
    output logic signed [DATA_W-1:0] data_out3,
    output logic signed [DATA_W-1:0] data_out4,
    output logic signed [DATA_W-1:0] data_out5,
    output logic signed [DATA_W-1:0] data_out6,
    output logic signed [DATA_W-1:0] data_out7,
    output logic signed [DATA_W-1:0] data_out8,
    output logic                     valid_out,
    output logic                     frame_done
);
    import dnn_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
`ifdef WINDOW_STRIDE2_EN
    localparam int LAST_R = ((IMG_H - 1) / 2) * 2;
    localparam int LAST_C = ((IMG_W - 1) / 2) * 2;
`else
    localparam int LAST_R = IMG_H - 1;
    localparam int LAST_C = IMG_W - 1;
`endif

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic              w_emit;
    logic              w_last;
    logic [DATA_W-1:0] w_lb0_q;
    logic [DATA_W-1:0] w_lb1_q;
    logic [DATA_W-1:0] r_win     [WIN_N];
    logic [DATA_W-1:0] w_win_nxt [WIN_N];
    logic [DATA_W-1:0] r_out     [WIN_N];

    // frame_start forces the current pixel to (0,0) whatever the counters say.
    assign w_col = frame_start ? '0 : r_col;
    assign w_row = frame_start ? '0 : r_row;

    always_comb begin
        w_emit = valid_in && (w_row >= RW'(2)) && (w_col >= CW'(2));
`ifdef WINDOW_STRIDE2_EN
        w_emit = w_emit && !w_row[0] && !w_col[0];
`endif
        w_last = (w_row == RW'(LAST_R)) && (w_col == CW'(LAST_C));
    end

    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
        .clk   (clk),
        .we    (valid_in),
        .addr  (w_col),
        .wdata (pixel_in),
        .rdata (w_lb0_q)
    );

    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
        .clk   (clk),
        .we    (valid_in),
        .addr  (w_col),
        .wdata (w_lb0_q),
        .rdata (w_lb1_q)
    );

    // Shift window left; right column is {two rows up, one row up, current}.
    always_comb begin
        for (int k = 0; k < WIN_K; k++) begin
            w_win_nxt[k*WIN_K]     = r_win[k*WIN_K + 1];
            w_win_nxt[k*WIN_K + 1] = r_win[k*WIN_K + 2];
        end
        w_win_nxt[2] = w_lb1_q;
        w_win_nxt[5] = w_lb0_q;
        w_win_nxt[8] = pixel_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            for (int k = 0; k < WIN_N; k++) begin
                r_win[k] <= '0;
                r_out[k] <= '0;
            end
        end else begin
            valid_out  <= w_emit;
            frame_done <= w_emit && w_last;
            if (valid_in) begin
                r_win <= w_win_nxt;
                if (w_emit) begin
                    r_out <= w_win_nxt;
                end
                if (w_col == CW'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= (w_row == RW'(IMG_H - 1)) ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end
        end
    end

    assign data_out0 = r_out[0];
    assign data_out1 = r_out[1];
    assign data_out2 = r_out[2];
    assign data_out3 = r_out[3];
    assign data_out4 = r_out[4];
    assign data_out5 = r_out[5];
    assign data_out6 = r_out[6];
    assign data_out7 = r_out[7];
    assign data_out8 = r_out[8];

endmodule
`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_gen_3x3
// Brief    : Randomized self-checking bench for window_gen_3x3 against a
//            frame-array reference model. Honours WINDOW_STRIDE2_EN.
// Revision : 1.0
// ============================================================================
module tb_window_gen_3x3;
`ifdef WINDOW_STRIDE2_EN
    localparam int W = 5;
    localparam int H = 5;
    localparam int N_WIN = ((H - 1) / 2) * ((W - 1) / 2);
`else
    localparam int W = 4;
    localparam int H = 4;
    localparam int N_WIN = (H - 2) * (W - 2);
`endif
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic frame_start = 1'b0;
    logic signed [DW-1:0] pixel_in = '0;
    logic signed [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
    logic valid_out, frame_done;
    logic [9*DW-1:0] dut_vec;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: the frame as a 2-D array plus the current position.
    logic [DW-1:0] img [H][W];
    int m_r, m_c, last_r, last_c;
    logic [9*DW-1:0] exp_vec;
    logic exp_valid, exp_done;

    window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .frame_start(frame_start),
        .pixel_in(pixel_in),
        .data_out0(d0), .data_out1(d1), .data_out2(d2), .data_out3(d3),
        .data_out4(d4), .data_out5(d5), .data_out6(d6), .data_out7(d7),
        .data_out8(d8), .valid_out(valid_out), .frame_done(frame_done)
    );

    assign dut_vec = {d0, d1, d2, d3, d4, d5, d6, d7, d8};

    always #5 clk = ~clk;

    function automatic bit emit_ok(int r, int c);
        bit ok;
        ok = (r >= 2) && (c >= 2);
`ifdef WINDOW_STRIDE2_EN
        ok = ok && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`endif
        return ok;
    endfunction

    task automatic model_reset();
        m_r = 0; m_c = 0;
        exp_vec = '0; exp_valid = 1'b0; exp_done = 1'b0;
    endtask

    // Drive one cycle, update the model, return 1 unit after the edge.
    task automatic step(input bit v, input bit fs, input logic [DW-1:0] pix);
        valid_in = v; frame_start = fs; pixel_in = pix;
        @(posedge clk);
        exp_valid = 1'b0; exp_done = 1'b0;
        if (v) begin
            if (fs) begin m_r = 0; m_c = 0; end
            img[m_r][m_c] = pix;
            if (emit_ok(m_r, m_c)) begin
                for (int k = 0; k < 9; k++)
                    exp_vec[(8-k)*DW +: DW] = img[m_r-2+k/3][m_c-2+k%3];
                exp_valid = 1'b1;
                exp_done  = (m_r == last_r) && (m_c == last_c);
            end
            m_c++;
            if (m_c == W) begin
                m_c = 0; m_r++;
                if (m_r == H) m_r = 0;
            end
        end
        #1;
        valid_in = 1'b0; frame_start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (valid_out !== 1'b0 || frame_done !== 1'b0 || dut_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_init: got v=%0b d=%0b win=%h, want all zero", valid_out, frame_done, dut_vec);
        end
        @(negedge clk); rst_n = 1'b1; model_reset();
        for (int i = 0; i < W*H + 7; i++) begin
            step(1'b1, i == 0, DW'($urandom));
            n_cmp++;
            if (valid_out !== exp_valid || frame_done !== exp_done || dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_pre: got v=%0b d=%0b win=%h, want v=%0b d=%0b win=%h",
                         valid_out, frame_done, dut_vec, exp_valid, exp_done, exp_vec);
            end
        end
        @(negedge clk); #2 rst_n = 1'b0; #1;
        n_cmp++;
        if (valid_out !== 1'b0 || frame_done !== 1'b0 || dut_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%0b d=%0b win=%h, want all zero", valid_out, frame_done, dut_vec);
        end
        @(negedge clk); rst_n = 1'b1; model_reset();
        // No frame_start: the first pixel after reset must still land at (0,0).
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, 1'b0, DW'($urandom));
            n_cmp++;
            if (valid_out !== exp_valid || frame_done !== exp_done || dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_post: got v=%0b d=%0b win=%h, want v=%0b d=%0b win=%h",
                         valid_out, frame_done, dut_vec, exp_valid, exp_done, exp_vec);
            end
        end
    endtask

    task automatic test_basic();
        int pulses = 0, dones = 0;
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, i == 0, DW'(i + 1));
            pulses += int'(valid_out); dones += int'(frame_done);
            n_cmp++;
            if (valid_out !== exp_valid || frame_done !== exp_done || dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL basic: got v=%0b d=%0b win=%h, want v=%0b d=%0b win=%h",
                         valid_out, frame_done, dut_vec, exp_valid, exp_done, exp_vec);
            end
            if (i == 2*W + 2) begin
                n_cmp++;
                if (valid_out !== 1'b1 || d4 !== DW'(W + 2) || d0 !== DW'(1)) begin
                    n_fail++;
                    $display("FAIL basic_first: got v=%0b d0=%0d d4=%0d, want v=1 d0=1 d4=%0d",
                             valid_out, d0, d4, W + 2);
                end
            end
        end
        n_cmp++;
        if (pulses != N_WIN || dones != 1) begin
            n_fail++;
            $display("FAIL basic_count: got pulses=%0d dones=%0d, want %0d and 1", pulses, dones, N_WIN);
        end
    endtask

    task automatic test_bubbles();
        int pulses = 0;
        for (int i = 0; i < W*H; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                step(1'b0, 1'($urandom), DW'($urandom));
                pulses += int'(valid_out);
                n_cmp++;
                if (valid_out !== exp_valid || frame_done !== exp_done || dut_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL bubble_gap: got v=%0b d=%0b win=%h, want v=%0b d=%0b win=%h",
                             valid_out, frame_done, dut_vec, exp_valid, exp_done, exp_vec);
                end
            end
            step(1'b1, i == 0, DW'(i + 1));
            pulses += int'(valid_out);
            n_cmp++;
            if (valid_out !== exp_valid || frame_done !== exp_done || dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL bubble_pix: got v=%0b d=%0b win=%h, want v=%0b d=%0b win=%h",
                         valid_out, frame_done, dut_vec, exp_valid, exp_done, exp_vec);
            end
        end
        n_cmp++;
        if (pulses != N_WIN) begin
            n_fail++;
            $display("FAIL bubble_count: got %0d pulses, want %0d", pulses, N_WIN);
        end
    endtask

    task automatic test_signed();
        logic [DW-1:0] pix;
        for (int i = 0; i < W*H; i++) begin
            pix = DW'($urandom);
            if (i == 0)     pix = 16'h8000;
            if (i == W + 1) pix = 16'hFFFF;
            if (i == 2*W+2) pix = 16'h7FFF;
            step(1'b1, i == 0, pix);
            n_cmp++;
            if (valid_out !== exp_valid || frame_done !== exp_done || dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL signed: got v=%0b d=%0b win=%h, want v=%0b d=%0b win=%h",
                         valid_out, frame_done, dut_vec, exp_valid, exp_done, exp_vec);
            end
            if (i == 2*W + 2) begin
                n_cmp++;
                if (d0 !== 16'h8000 || d4 !== 16'hFFFF || d8 !== 16'h7FFF) begin
                    n_fail++;
                    $display("FAIL signed_exact: got d0=%h d4=%h d8=%h, want 8000 ffff 7fff", d0, d4, d8);
                end
            end
        end
    endtask

    task automatic test_resync();
        int dones = 0;
        for (int i = 0; i < W + 2; i++) begin
            step(1'b1, i == 0, DW'($urandom));
            dones += int'(frame_done);
        end
        step(1'b1, 1'b1, DW'(100));
        step(1'b1, 1'b0, DW'($urandom));
        step(1'b1, 1'b0, DW'($urandom));
        n_cmp++;
        if (valid_out !== 1'b0 || dones != 0 || dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL resync_partial: got v=%0b dones=%0d win=%h, want v=0 dones=0 win=%h",
                     valid_out, dones, dut_vec, exp_vec);
        end
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, i == 0, DW'(i + 1));
            dones += int'(frame_done);
            n_cmp++;
            if (valid_out !== exp_valid || frame_done !== exp_done || dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL resync: got v=%0b d=%0b win=%h, want v=%0b d=%0b win=%h",
                         valid_out, frame_done, dut_vec, exp_valid, exp_done, exp_vec);
            end
        end
        n_cmp++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL resync_done: got %0d frame_done pulses, want 1", dones);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < W*H; i++) begin
                if ($urandom_range(0, 2) == 0) step(1'b0, 1'($urandom), DW'($urandom));
                step(1'b1, i == 0, DW'($urandom));
                n_cmp++;
                if (valid_out !== exp_valid || frame_done !== exp_done || dut_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL random: got v=%0b d=%0b win=%h, want v=%0b d=%0b win=%h",
                             valid_out, frame_done, dut_vec, exp_valid, exp_done, exp_vec);
                end
            end
        end
    endtask

    initial begin
        last_r = 0; last_c = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (emit_ok(r, c)) begin last_r = r; last_c = c; end
        model_reset();
        test_reset();
        test_basic();
        test_bubbles();
        test_signed();
        test_resync();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
